rf_wr_arbiter: RTL and testbench

//  Shares the single register-file write port between in-order pipeline writeback and
//  the long-latency unit (LLU: mul/div/AMO), which completes out of order.

---
 rtl/rf_wr_arbiter.sv | 78 +++++++
 tb/tb_rf_wr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the rf write port between pipeline WB and buffered LLU results,
// tracks pending LLU destinations and raises the decode stall for hazards and starvation.
module rf_wr_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  wb_rf_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  llu_issue,
  input  logic [4:0]            llu_issue_rd,
  input  logic                  llu_res_valid,
  output logic                  llu_res_ready,
  input  logic [4:0]            llu_res_rd,
  input  logic [DATA_WIDTH-1:0] llu_res_data,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  output logic                  rf_wr_en,
  output logic [4:0]            rf_rd,
  output logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  id_stall
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0] FULL = (AW + 1)'(BUF_DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [4:0]            buf_rd   [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [31:0]           pending, pend_set, pend_clr;
  logic [SW-1:0]         starve_cnt;
  logic                  empty, wb_win, push, pop, starve_stall;

  assign empty         = count == '0;
  assign wb_win        = wb_rf_en && wb_rd != 5'd0;
  assign pop           = !wb_win && !empty;
  assign llu_res_ready = count != FULL;
  // x0 results are accepted but silently dropped
  assign push          = llu_res_valid && llu_res_ready && llu_res_rd != 5'd0;
  assign starve_stall  = starve_cnt == SLIM;

  assign rf_wr_en   = wb_win || !empty;
  assign rf_rd      = wb_win ? wb_rd : (empty ? 5'd0 : buf_rd[rd_ptr]);
  assign rf_rd_data = wb_win ? wb_data : (empty ? '0 : buf_data[rd_ptr]);

  assign pend_set = (llu_issue && llu_issue_rd != 5'd0) ? 32'd1 << llu_issue_rd : 32'd0;
  assign pend_clr = pop ? 32'd1 << buf_rd[rd_ptr] : 32'd0;
  assign id_stall = pending[id_rs1] | pending[id_rs2] | pending[id_rd] | starve_stall;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count      <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      pending    <= ((pending & ~pend_clr) | pend_set) & ~32'd1;
      starve_cnt <= (empty || pop) ? '0 : (starve_stall ? starve_cnt : starve_cnt + SW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[wr_ptr]   <= llu_res_rd;
      buf_data[wr_ptr] <= llu_res_data;
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed checks of arbitration, FIFO, scoreboard and starvation stall.
module tb_rf_wr_arbiter;
  logic        clk = 0;
  logic        arst_n;
  logic        wb_rf_en, llu_issue, llu_res_valid, llu_res_ready;
  logic [4:0]  wb_rd, llu_issue_rd, llu_res_rd, id_rs1, id_rs2, id_rd, rf_rd;
  logic [31:0] wb_data, llu_res_data, rf_rd_data;
  logic        rf_wr_en, id_stall;
  int          errors = 0;
  int          checks = 0;

  rf_wr_arbiter dut (
    .clk(clk), .arst_n(arst_n),
    .wb_rf_en(wb_rf_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_issue(llu_issue), .llu_issue_rd(llu_issue_rd),
    .llu_res_valid(llu_res_valid), .llu_res_ready(llu_res_ready),
    .llu_res_rd(llu_res_rd), .llu_res_data(llu_res_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data), .id_stall(id_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n = 0; wb_rf_en = 0; wb_rd = 0; wb_data = 0;
    llu_issue = 0; llu_issue_rd = 0; llu_res_valid = 0; llu_res_rd = 0; llu_res_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1;
    #1;
    chk("rst_ready", llu_res_ready, 1);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_stall", id_stall, 0);
    // reset with two buffered results and a pending bit
    wb_rf_en = 1; wb_rd = 3; wb_data = 32'h33;
    llu_issue = 1; llu_issue_rd = 12;
    llu_res_valid = 1; llu_res_rd = 10; llu_res_data = 32'hA;
    tick();
    llu_issue = 0; llu_res_rd = 11; llu_res_data = 32'hB;
    tick();
    llu_res_valid = 0; id_rs1 = 12;
    #1;
    chk("pre_rst_full", llu_res_ready, 0);
    chk("pre_rst_stall", id_stall, 1);
    chk("pre_rst_wb_rd", rf_rd, 3);
    arst_n = 0; wb_rf_en = 0;
    #1;
    chk("mid_rst_ready", llu_res_ready, 1);
    chk("mid_rst_wr_en", rf_wr_en, 0);
    chk("mid_rst_rd", rf_rd, 0);
    chk("mid_rst_data", rf_rd_data, 0);
    chk("mid_rst_stall", id_stall, 0);
    tick();
    arst_n = 1; id_rs1 = 0;
    tick();
    chk("post_rst_wr_en", rf_wr_en, 0);
    // basic issue / writeback / stall release
    llu_issue = 1; llu_issue_rd = 5;
    tick();
    llu_issue = 0; id_rs1 = 5;
    #1;
    chk("basic_stall_set", id_stall, 1);
    llu_res_valid = 1; llu_res_rd = 5; llu_res_data = 32'hDEAD;
    #1;
    chk("basic_no_fallthru", rf_wr_en, 0);
    tick();
    llu_res_valid = 0;
    #1;
    chk("basic_wr_en", rf_wr_en, 1);
    chk("basic_rd", rf_rd, 5);
    chk("basic_data", rf_rd_data, 32'hDEAD);
    chk("basic_stall_hold", id_stall, 1);
    tick();
    chk("basic_stall_clr", id_stall, 0);
    chk("basic_idle", rf_wr_en, 0);
    id_rs1 = 0;
    // conflict and starvation
    wb_rf_en = 1; wb_rd = 3; wb_data = 32'h333;
    llu_issue = 1; llu_issue_rd = 7;
    tick();
    llu_issue = 0; llu_res_valid = 1; llu_res_rd = 7; llu_res_data = 32'h777;
    tick();
    llu_res_valid = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("starve_pre_stall", id_stall, 0);
      chk("starve_wb_rd", rf_rd, 3);
      tick();
    end
    chk("starve_stall", id_stall, 1);
    tick();
    chk("starve_sat", id_stall, 1);
    wb_rf_en = 0;
    #1;
    chk("starve_wr_en", rf_wr_en, 1);
    chk("starve_head_rd", rf_rd, 7);
    chk("starve_head_data", rf_rd_data, 32'h777);
    chk("starve_stall_hold", id_stall, 1);
    tick();
    chk("starve_release", id_stall, 0);
    chk("starve_idle", rf_wr_en, 0);
    // full FIFO with third result held off
    wb_rf_en = 1; wb_rd = 3;
    llu_res_valid = 1; llu_res_rd = 20; llu_res_data = 32'hA0;
    tick();
    llu_res_rd = 21; llu_res_data = 32'hA1;
    tick();
    llu_res_rd = 22; llu_res_data = 32'hA2;
    #1;
    chk("full_ready0", llu_res_ready, 0);
    tick();
    chk("full_ready_held", llu_res_ready, 0);
    wb_rf_en = 0;
    #1;
    chk("full_head0_rd", rf_rd, 20);
    chk("full_head0_data", rf_rd_data, 32'hA0);
    tick();
    chk("full_ready1", llu_res_ready, 1);
    chk("full_head1_rd", rf_rd, 21);
    chk("full_head1_data", rf_rd_data, 32'hA1);
    tick();
    llu_res_valid = 0;
    #1;
    chk("full_head2_rd", rf_rd, 22);
    chk("full_head2_data", rf_rd_data, 32'hA2);
    tick();
    chk("full_drained", rf_wr_en, 0);
    // x0 handling
    wb_rf_en = 1; wb_rd = 3;
    llu_res_valid = 1; llu_res_rd = 13; llu_res_data = 32'h1313;
    tick();
    llu_res_valid = 0; wb_rd = 0; wb_data = 32'hFFFF;
    #1;
    chk("x0_wb_head_en", rf_wr_en, 1);
    chk("x0_wb_head_rd", rf_rd, 13);
    chk("x0_wb_head_data", rf_rd_data, 32'h1313);
    tick();
    chk("x0_wb_dropped", rf_wr_en, 0);
    wb_rf_en = 0;
    llu_issue = 1; llu_issue_rd = 0;
    llu_res_valid = 1; llu_res_rd = 0; llu_res_data = 32'hBAD;
    #1;
    chk("x0_res_ready", llu_res_ready, 1);
    tick();
    llu_issue = 0; llu_res_valid = 0;
    #1;
    chk("x0_res_no_write", rf_wr_en, 0);
    chk("x0_no_pending", id_stall, 0);
    // set wins over clear on the same bit
    llu_issue = 1; llu_issue_rd = 9;
    tick();
    llu_issue = 0; llu_res_valid = 1; llu_res_rd = 9; llu_res_data = 32'h99;
    tick();
    llu_res_valid = 0; llu_issue = 1; llu_issue_rd = 9;
    #1;
    chk("same_head_rd", rf_rd, 9);
    tick();
    llu_issue = 0; id_rd = 9;
    #1;
    chk("same_pending_rd", id_stall, 1);
    chk("same_idle", rf_wr_en, 0);
    id_rd = 0; id_rs2 = 9;
    #1;
    chk("same_pending_rs2", id_stall, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
